// File: rtl/mmu_access_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : mmu_access_arbiter
// Description : Two-into-one access arbiter in front of the MMU. Port s0
//               (instruction side) and port s1 (data side) compete for a
//               single registered output buffer. The master port is driven
//               only from that buffer, so every accepted beat appears on
//               m_*_o exactly one cycle after the slave handshake. The block
//               sustains one beat per cycle while the master is not full.
//
//               Handshake on every port: a beat transfers when valid=1 and
//               full=0.
//
// Widths      : `XLEN (address/data) and `MMU_USER_W (user sideband) are
//               normally supplied by prv664_config.svh. Fallback values are
//               defined below so the file also elaborates stand-alone.
//
// Build option: MMU_ARB_RR_EN
//               defined   -> round-robin on conflict; the pointer flips to
//                            the port that did not win on every load.
//               undefined -> fixed priority, s1 (data side) wins conflicts;
//                            no pointer register exists.
//
// Ports       :
//   clk_i        in   1           clock, all state on rising edge
//   srst_i       in   1           synchronous active-high reset
//   flush_i      in   1           drop buffered beat, accept nothing
//   sK_id_i      in   8           access id               (K = 0, 1)
//   sK_addr_i    in   XLEN        access address
//   sK_data_i    in   XLEN        store data
//   sK_opcode_i  in   5           access opcode
//   sK_funct_i   in   10          access function
//   sK_user_i    in   MMU_USER_W  user sideband
//   sK_valid_i   in   1           access valid
//   sK_full_o    out  1           back-pressure to slave K
//   m_id_o .. m_user_o  out       buffered beat fields
//   m_valid_o    out  1           buffered beat valid
//   m_full_i     in   1           back-pressure from master
//   m_src_o      out  1           source of buffered beat (0 = s0, 1 = s1)
//
// Revision    : 1.0  initial release
//==============================================================================

`ifndef XLEN
`define XLEN 64
`endif
`ifndef MMU_USER_W
`define MMU_USER_W 8
`endif

module mmu_access_arbiter (
    input  logic                   clk_i,
    input  logic                   srst_i,
    input  logic                   flush_i,

    // slave port 0: instruction side
    input  logic [7:0]             s0_id_i,
    input  logic [`XLEN-1:0]       s0_addr_i,
    input  logic [`XLEN-1:0]       s0_data_i,
    input  logic [4:0]             s0_opcode_i,
    input  logic [9:0]             s0_funct_i,
    input  logic [`MMU_USER_W-1:0] s0_user_i,
    input  logic                   s0_valid_i,
    output logic                   s0_full_o,

    // slave port 1: data side
    input  logic [7:0]             s1_id_i,
    input  logic [`XLEN-1:0]       s1_addr_i,
    input  logic [`XLEN-1:0]       s1_data_i,
    input  logic [4:0]             s1_opcode_i,
    input  logic [9:0]             s1_funct_i,
    input  logic [`MMU_USER_W-1:0] s1_user_i,
    input  logic                   s1_valid_i,
    output logic                   s1_full_o,

    // master port
    output logic [7:0]             m_id_o,
    output logic [`XLEN-1:0]       m_addr_o,
    output logic [`XLEN-1:0]       m_data_o,
    output logic [4:0]             m_opcode_o,
    output logic [9:0]             m_funct_o,
    output logic [`MMU_USER_W-1:0] m_user_o,
    output logic                   m_valid_o,
    input  logic                   m_full_i,
    output logic                   m_src_o
);

    //--------------------------------------------------------------------------
    // Output buffer (single entry)
    //--------------------------------------------------------------------------
    logic                   r_obuf_v;
    logic [7:0]             r_id;
    logic [`XLEN-1:0]       r_addr;
    logic [`XLEN-1:0]       r_data;
    logic [4:0]             r_opcode;
    logic [9:0]             r_funct;
    logic [`MMU_USER_W-1:0] r_user;
    logic                   r_src;

    //--------------------------------------------------------------------------
    // Combinational control
    //--------------------------------------------------------------------------
    logic w_can_load;   // buffer can take a new beat at the next edge
    logic w_grant0;     // s0 wins this cycle (if it can load)
    logic w_grant1;     // s1 wins this cycle (if it can load)
    logic w_load;       // a slave beat is accepted this cycle
    logic w_issue;      // buffered beat leaves on the master port this cycle

    // The buffer is free when empty or when its beat is leaving right now.
    // Flush and reset both forbid accepting anything in their cycle so that
    // no slave ever sees an accept whose beat is then thrown away.
    assign w_can_load = (~r_obuf_v | ~m_full_i) & ~flush_i & ~srst_i;

`ifdef MMU_ARB_RR_EN
    // Round-robin pointer: names the port that wins the next conflict.
    logic r_rr_ptr;

    assign w_grant0 = s0_valid_i & (~s1_valid_i | ~r_rr_ptr);
    assign w_grant1 = s1_valid_i & (~s0_valid_i |  r_rr_ptr);

    // Pointer moves only on an actual load, so a flushed or stalled cycle
    // leaves the fairness order untouched.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_rr_ptr <= 1'b0;
        end else if (w_load) begin
            r_rr_ptr <= ~w_grant1;
        end
    end
`else
    // Fixed priority: the data side always wins a conflict.
    assign w_grant1 = s1_valid_i;
    assign w_grant0 = s0_valid_i & ~s1_valid_i;
`endif

    assign w_load  = w_can_load & (w_grant0 | w_grant1);
    assign w_issue = r_obuf_v & ~m_full_i & ~flush_i;

    // An idle or losing port sees full=1 as well; only the port actually
    // being accepted sees full=0.
    assign s0_full_o = ~(w_grant0 & w_can_load);
    assign s1_full_o = ~(w_grant1 & w_can_load);

    //--------------------------------------------------------------------------
    // Buffer update
    //--------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_obuf_v <= 1'b0;
            r_id     <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_opcode <= '0;
            r_funct  <= '0;
            r_user   <= '0;
            r_src    <= 1'b0;
        end else if (w_load) begin
            // Covers both an empty buffer and issue-with-reload in one edge.
            r_obuf_v <= 1'b1;
            r_src    <= w_grant1;
            if (w_grant1) begin
                r_id     <= s1_id_i;
                r_addr   <= s1_addr_i;
                r_data   <= s1_data_i;
                r_opcode <= s1_opcode_i;
                r_funct  <= s1_funct_i;
                r_user   <= s1_user_i;
            end else begin
                r_id     <= s0_id_i;
                r_addr   <= s0_addr_i;
                r_data   <= s0_data_i;
                r_opcode <= s0_opcode_i;
                r_funct  <= s0_funct_i;
                r_user   <= s0_user_i;
            end
        end else if (flush_i || w_issue) begin
            // Fields are left as they are; only the valid bit matters.
            r_obuf_v <= 1'b0;
        end
        // Otherwise the beat is stalled by m_full_i: every field holds.
    end

    //--------------------------------------------------------------------------
    // Master port: driven from the buffer only
    //--------------------------------------------------------------------------
    // Valid is masked by flush and by reset so a beat being discarded is
    // never presented to the master, not even in the discarding cycle.
    assign m_valid_o  = r_obuf_v & ~flush_i & ~srst_i;
    assign m_id_o     = r_id;
    assign m_addr_o   = r_addr;
    assign m_data_o   = r_data;
    assign m_opcode_o = r_opcode;
    assign m_funct_o  = r_funct;
    assign m_user_o   = r_user;
    assign m_src_o    = r_src;

endmodule

`default_nettype wire

// File: tb/tb_mmu_access_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_mmu_access_arbiter
// Description : Self-checking bench for mmu_access_arbiter. Accepted beats
//               are pushed into a scoreboard queue by the scenario tasks and
//               popped/compared whenever the master port issues a beat.
// Revision    : 1.0  initial release
//==============================================================================

`ifndef XLEN
`define XLEN 64
`endif
`ifndef MMU_USER_W
`define MMU_USER_W 8
`endif

module tb_mmu_access_arbiter;

    localparam int c_XL = `XLEN;
    localparam int c_UW = `MMU_USER_W;

    typedef struct packed {
        logic [7:0]      id;
        logic [c_XL-1:0] addr;
        logic [c_XL-1:0] data;
        logic [4:0]      opcode;
        logic [9:0]      funct;
        logic [c_UW-1:0] user;
        logic            src;
    } beat_t;

    logic            clk = 1'b0;
    logic            srst = 1'b1;
    logic            flush = 1'b0;
    logic [7:0]      s0_id = '0,     s1_id = '0;
    logic [c_XL-1:0] s0_addr = '0,   s1_addr = '0;
    logic [c_XL-1:0] s0_data = '0,   s1_data = '0;
    logic [4:0]      s0_opcode = '0, s1_opcode = '0;
    logic [9:0]      s0_funct = '0,  s1_funct = '0;
    logic [c_UW-1:0] s0_user = '0,   s1_user = '0;
    logic            s0_valid = 1'b0, s1_valid = 1'b0;
    logic            s0_full, s1_full;
    logic [7:0]      m_id;
    logic [c_XL-1:0] m_addr, m_data;
    logic [4:0]      m_opcode;
    logic [9:0]      m_funct;
    logic [c_UW-1:0] m_user;
    logic            m_valid;
    logic            m_full = 1'b0;
    logic            m_src;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t sb_q[$];
    beat_t mon_got, mon_exp;

    always #5 clk = ~clk;

    mmu_access_arbiter u_dut (
        .clk_i(clk), .srst_i(srst), .flush_i(flush),
        .s0_id_i(s0_id), .s0_addr_i(s0_addr), .s0_data_i(s0_data),
        .s0_opcode_i(s0_opcode), .s0_funct_i(s0_funct), .s0_user_i(s0_user),
        .s0_valid_i(s0_valid), .s0_full_o(s0_full),
        .s1_id_i(s1_id), .s1_addr_i(s1_addr), .s1_data_i(s1_data),
        .s1_opcode_i(s1_opcode), .s1_funct_i(s1_funct), .s1_user_i(s1_user),
        .s1_valid_i(s1_valid), .s1_full_o(s1_full),
        .m_id_o(m_id), .m_addr_o(m_addr), .m_data_o(m_data),
        .m_opcode_o(m_opcode), .m_funct_o(m_funct), .m_user_o(m_user),
        .m_valid_o(m_valid), .m_full_i(m_full), .m_src_o(m_src)
    );

    // Beat fields are derived from (src, addr, id) so every field is distinct.
    function automatic beat_t mk_beat(input logic src, input logic [c_XL-1:0] addr,
                                      input logic [7:0] id);
        beat_t b;
        b.id     = id;
        b.addr   = addr;
        b.data   = ~addr ^ c_XL'(id);
        b.opcode = id[4:0] ^ 5'h0A;
        b.funct  = {id[1:0], ~id};
        b.user   = c_UW'(id ^ 8'h3C);
        b.src    = src;
        return b;
    endfunction

    task automatic set_s0(input logic v, input beat_t b);
        s0_valid = v; s0_id = b.id; s0_addr = b.addr; s0_data = b.data;
        s0_opcode = b.opcode; s0_funct = b.funct; s0_user = b.user;
    endtask

    task automatic set_s1(input logic v, input beat_t b);
        s1_valid = v; s1_id = b.id; s1_addr = b.addr; s1_data = b.data;
        s1_opcode = b.opcode; s1_funct = b.funct; s1_user = b.user;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        next_cycle();
        srst = 1'b1; flush = 1'b0; m_full = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0;
        next_cycle();
        srst = 1'b0;
    endtask

    // Scoreboard monitor: a beat issues when valid=1 and full=0.
    always @(negedge clk) begin
        if (m_valid && !m_full) begin
            mon_got = '{id: m_id, addr: m_addr, data: m_data, opcode: m_opcode,
                        funct: m_funct, user: m_user, src: m_src};
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: issued beat %h, required no beat", mon_got);
            end else begin
                mon_exp = sb_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL sb_beat: got %h required %h", mon_got, mon_exp);
                end
            end
        end
    end

    task automatic test_reset();
        next_cycle();
        srst = 1'b1; s0_valid = 1'b1; s1_valid = 1'b1; m_full = 1'b0;
        @(negedge clk);
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b required 0", m_valid); end
        n_tests++; if (s0_full !== 1'b1) begin n_fail++; $display("FAIL rst_s0_full: got %b required 1", s0_full); end
        n_tests++; if (s1_full !== 1'b1) begin n_fail++; $display("FAIL rst_s1_full: got %b required 1", s1_full); end
        next_cycle();
        srst = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid: got %b required 0", m_valid); end
        n_tests++; if (m_src !== 1'b0) begin n_fail++; $display("FAIL post_rst_src: got %b required 0", m_src); end
        n_tests++;
        if ({m_id, m_addr, m_data, m_opcode, m_funct, m_user} !== '0) begin
            n_fail++;
            $display("FAIL post_rst_fields: got id=%h addr=%h data=%h op=%h fn=%h user=%h required all 0",
                     m_id, m_addr, m_data, m_opcode, m_funct, m_user);
        end
    endtask

    task automatic test_single();
        beat_t b;
        apply_reset();
        b = mk_beat(1'b0, c_XL'('h1000), 8'h05);
        set_s0(1'b1, b);
        @(negedge clk);
        n_tests++; if (s0_full !== 1'b0) begin n_fail++; $display("FAIL single_s0_full: got %b required 0", s0_full); end
        n_tests++; if (s1_full !== 1'b1) begin n_fail++; $display("FAIL single_s1_full_idle: got %b required 1", s1_full); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_c0_valid: got %b required 0", m_valid); end
        sb_q.push_back(b);
        next_cycle();
        set_s0(1'b0, b);
        @(negedge clk);
        n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL single_c1_valid: got %b required 1", m_valid); end
        n_tests++; if (m_addr !== c_XL'('h1000)) begin n_fail++; $display("FAIL single_addr: got %h required 1000", m_addr); end
        n_tests++; if (m_id !== 8'h05) begin n_fail++; $display("FAIL single_id: got %h required 05", m_id); end
        n_tests++; if (m_src !== 1'b0) begin n_fail++; $display("FAIL single_src: got %b required 0", m_src); end
        next_cycle();
        @(negedge clk);
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_clear: got %b required 0", m_valid); end
    endtask

    task automatic test_conflict();
        beat_t b0, b1;
        logic  w, prev_w;
        int    k0, k1;
        apply_reset();
        k0 = 0; k1 = 0; prev_w = 1'b0;
        b0 = mk_beat(1'b0, c_XL'('h4000), 8'h40);
        b1 = mk_beat(1'b1, c_XL'('h4800), 8'h80);
        for (int i = 0; i < 4; i++) begin
            set_s0(1'b1, b0);
            set_s1(1'b1, b1);
`ifdef MMU_ARB_RR_EN
            w = i[0];
`else
            w = 1'b1;
`endif
            @(negedge clk);
            n_tests++; if (s0_full !== w) begin n_fail++; $display("FAIL conf_s0_full[%0d]: got %b required %b", i, s0_full, w); end
            n_tests++; if (s1_full !== ~w) begin n_fail++; $display("FAIL conf_s1_full[%0d]: got %b required %b", i, s1_full, ~w); end
            if (i > 0) begin
                n_tests++; if (m_src !== prev_w) begin n_fail++; $display("FAIL conf_src[%0d]: got %b required %b", i - 1, m_src, prev_w); end
            end
            if (w) begin
                sb_q.push_back(b1); k1++;
                b1 = mk_beat(1'b1, c_XL'('h4800 + 16 * k1), 8'(8'h80 + k1));
            end else begin
                sb_q.push_back(b0); k0++;
                b0 = mk_beat(1'b0, c_XL'('h4000 + 16 * k0), 8'(8'h40 + k0));
            end
            prev_w = w;
            next_cycle();
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (m_src !== prev_w) begin n_fail++; $display("FAIL conf_src[3]: got %b required %b", m_src, prev_w); end
    endtask

    task automatic test_stall();
        beat_t a, b;
        apply_reset();
        a = mk_beat(1'b0, c_XL'('h2000), 8'h20);
        b = mk_beat(1'b1, c_XL'('h3000), 8'h31);
        set_s0(1'b1, a);
        @(negedge clk);
        n_tests++; if (s0_full !== 1'b0) begin n_fail++; $display("FAIL stall_load_a: got %b required 0", s0_full); end
        sb_q.push_back(a);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            set_s0(1'b0, a); set_s1(1'b1, b); m_full = 1'b1;
            @(negedge clk);
            n_tests++; if (m_addr !== c_XL'('h2000)) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h required 2000", i, m_addr); end
            n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b required 1", i, m_valid); end
            n_tests++; if (s1_full !== 1'b1) begin n_fail++; $display("FAIL stall_s1_full[%0d]: got %b required 1", i, s1_full); end
            n_tests++; if (s0_full !== 1'b1) begin n_fail++; $display("FAIL stall_s0_full[%0d]: got %b required 1", i, s0_full); end
        end
        next_cycle();
        m_full = 1'b0;
        @(negedge clk);
        n_tests++; if (s1_full !== 1'b0) begin n_fail++; $display("FAIL stall_release_s1: got %b required 0", s1_full); end
        sb_q.push_back(b);
        next_cycle();
        set_s1(1'b0, b);
        @(negedge clk);
        n_tests++; if (m_addr !== c_XL'('h3000)) begin n_fail++; $display("FAIL stall_next_addr: got %h required 3000", m_addr); end
        n_tests++; if (m_src !== 1'b1) begin n_fail++; $display("FAIL stall_next_src: got %b required 1", m_src); end
    endtask

    task automatic test_flush();
        beat_t a, b;
        apply_reset();
        a = mk_beat(1'b0, c_XL'('h5000), 8'h50);
        b = mk_beat(1'b0, c_XL'('h5100), 8'h51);
        set_s0(1'b1, a);
        @(negedge clk);
        n_tests++; if (s0_full !== 1'b0) begin n_fail++; $display("FAIL flush_load_a: got %b required 0", s0_full); end
        next_cycle();
        flush = 1'b1; set_s0(1'b1, b);
        @(negedge clk);
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_c0: got %b required 0", m_valid); end
        n_tests++; if (s0_full !== 1'b1) begin n_fail++; $display("FAIL flush_s0_full: got %b required 1", s0_full); end
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_c1: got %b required 0", m_valid); end
        n_tests++; if (s0_full !== 1'b0) begin n_fail++; $display("FAIL flush_accept_after: got %b required 0", s0_full); end
        sb_q.push_back(b);
        next_cycle();
        set_s0(1'b0, b);
        @(negedge clk);
        n_tests++; if (m_addr !== c_XL'('h5100)) begin n_fail++; $display("FAIL flush_next_addr: got %h required 5100", m_addr); end
    endtask

    task automatic test_reset_stall();
        beat_t c, d;
        apply_reset();
        c = mk_beat(1'b1, c_XL'('h6000), 8'h60);
        d = mk_beat(1'b0, c_XL'('h6100), 8'h61);
        set_s1(1'b1, c); m_full = 1'b1;
        @(negedge clk);
        n_tests++; if (s1_full !== 1'b0) begin n_fail++; $display("FAIL rs_load: got %b required 0", s1_full); end
        next_cycle();
        set_s1(1'b0, c);
        @(negedge clk);
        n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL rs_stalled: got %b required 1", m_valid); end
        next_cycle();
        srst = 1'b1; set_s0(1'b1, d);
        @(negedge clk);
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rs_valid_in_rst: got %b required 0", m_valid); end
        n_tests++; if ({s0_full, s1_full} !== 2'b11) begin n_fail++; $display("FAIL rs_full_in_rst: got %b required 11", {s0_full, s1_full}); end
        next_cycle();
        srst = 1'b0; m_full = 1'b0; set_s0(1'b0, d);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rs_no_issue[%0d]: got %b required 0", i, m_valid); end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        beat_t b;
        logic  pend, model_v, acc;
        int    k;
        apply_reset();
        k = 0; pend = 1'b0; model_v = 1'b0;
        b = mk_beat(1'b1, c_XL'('h8000), 8'h00);
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (!pend) pend = ($urandom_range(0, 3) != 0);
            set_s1(pend, b);
            m_full = (cyc < 40) ? ($urandom_range(0, 2) == 0) : 1'b0;
            @(negedge clk);
            acc = pend & (~model_v | ~m_full);
            n_tests++; if (m_valid !== model_v) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b required %b", cyc, m_valid, model_v); end
            n_tests++; if (s1_full !== ~acc) begin n_fail++; $display("FAIL b2b_s1_full[%0d]: got %b required %b", cyc, s1_full, ~acc); end
            n_tests++; if (s0_full !== 1'b1) begin n_fail++; $display("FAIL b2b_s0_idle[%0d]: got %b required 1", cyc, s0_full); end
            if (acc) begin
                sb_q.push_back(b);
                k++;
                b = mk_beat(1'b1, c_XL'('h8000 + 8 * k), 8'(k));
                pend = 1'b0;
            end
            model_v = acc | (model_v & m_full);
            next_cycle();
        end
        s1_valid = 1'b0; m_full = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        n_tests++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d pending beats required 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_conflict();
        test_stall();
        test_flush();
        test_reset_stall();
        test_back_to_back();
        repeat (2) next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
